// File: rtl/fb_pkg.sv
// Shared frame-buffer definitions: FSM state encoding and default pixel-store geometry
// that is also used by the VGA pixel pipeline.
package fb_pkg;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        CLEAR = 2'd1,
        DRAW  = 2'd2
    } fb_state_t;

    localparam int FB_PIXEL_COUNT = 1024;
    localparam int FB_PIXEL_AW    = 10;
    localparam int FB_PIXEL_DW    = 1;

endpackage

// File: rtl/fb_pingpong_clear_if.sv
// Renderer / scan-out bundle of the ping-pong frame store; the renderer side is the
// master, the frame store is the slave.
interface fb_pingpong_clear_if
    import fb_pkg::*;
#(
    parameter int DATA_WIDTH = FB_PIXEL_DW,
    parameter int ADDR_WIDTH = FB_PIXEL_AW
);
    logic                  wr_valid;
    logic                  wr_ready;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  swap_req;
    logic                  swap_ack;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  display_sel;
    logic                  clear_busy;

    modport master (
        output wr_valid, wr_addr, wr_data, swap_req, rd_addr,
        input  wr_ready, swap_ack, rd_data, display_sel, clear_busy
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, swap_req, rd_addr,
        output wr_ready, swap_ack, rd_data, display_sel, clear_busy
    );
endinterface

// File: rtl/fb_bank_sdp.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// Callers guarantee in-range write addresses; out-of-range read data is masked upstream.
module fb_bank_sdp #(
    parameter int DATA_WIDTH = 1,
    parameter int DEPTH      = 1024,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int IW = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic [IW-1:0]         widx;
    logic [IW-1:0]         ridx;

    assign widx = IW'(waddr);
    assign ridx = IW'(raddr);

    always_ff @(posedge clk) begin
        if (we) begin
            mem[widx] <= wdata;
        end
        rdata_reg <= mem[ridx];
    end

    assign rdata = rdata_reg;
endmodule

// File: rtl/fb_pingpong_clear.sv
// Double-buffered frame store with hardware background clear after each bank swap.
// Optional macro FB_READ_REG_EN adds an output register on rd_data (2-cycle read latency).
module fb_pingpong_clear
    import fb_pkg::*;
#(
    parameter int                    DATA_WIDTH  = FB_PIXEL_DW,
    parameter int                    DEPTH       = FB_PIXEL_COUNT,
    parameter int                    ADDR_WIDTH  = FB_PIXEL_AW,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic               clk,
    input  logic               reset,
    fb_pingpong_clear_if.slave bus
);
    localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

    fb_state_t             state_reg, state_next;
    logic [ADDR_WIDTH-1:0] clear_addr_reg, clear_addr_next;
    logic                  display_sel_reg;
    logic                  rd_sel_reg;
    logic                  rd_oor_reg;
    logic                  swap_ack;
    logic                  wr_in_range;
    logic [DATA_WIDTH-1:0] bank_rdata [2];
    logic [DATA_WIDTH-1:0] rd_mux;

    assign swap_ack    = (state_reg == DRAW) && bus.swap_req;
    assign wr_in_range = ({1'b0, bus.wr_addr} < DEPTH_W);

    always_comb begin
        state_next      = state_reg;
        clear_addr_next = clear_addr_reg;
        case (state_reg)
            INIT, CLEAR: begin
                clear_addr_next = clear_addr_reg + 1'b1;
                if (clear_addr_reg == LAST_ADDR) begin
                    state_next      = DRAW;
                    clear_addr_next = '0;
                end
            end
            DRAW: begin
                if (swap_ack) begin
                    state_next      = CLEAR;
                    clear_addr_next = '0;
                end
            end
            default: begin
                state_next      = INIT;
                clear_addr_next = '0;
            end
        endcase
    end

    // The read-bank select follows the post-swap value so a read issued in the
    // swap_ack cycle already targets the new display bank.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg       <= INIT;
            clear_addr_reg  <= '0;
            display_sel_reg <= 1'b0;
            rd_sel_reg      <= 1'b0;
            rd_oor_reg      <= 1'b1;
        end else begin
            state_reg       <= state_next;
            clear_addr_reg  <= clear_addr_next;
            display_sel_reg <= display_sel_reg ^ swap_ack;
            rd_sel_reg      <= display_sel_reg ^ swap_ack;
            rd_oor_reg      <= !({1'b0, bus.rd_addr} < DEPTH_W);
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        logic                  we;
        logic [ADDR_WIDTH-1:0] waddr;
        logic [DATA_WIDTH-1:0] wdata;
        logic                  is_draw;

        assign is_draw = (display_sel_reg != 1'(gi));

        // INIT clears both banks together; otherwise only the draw bank is written.
        always_comb begin
            we    = 1'b0;
            waddr = clear_addr_reg;
            wdata = CLEAR_VALUE;
            case (state_reg)
                INIT:  we = 1'b1;
                CLEAR: we = is_draw;
                DRAW: begin
                    we    = is_draw && bus.wr_valid && wr_in_range;
                    waddr = bus.wr_addr;
                    wdata = bus.wr_data;
                end
                default: we = 1'b0;
            endcase
        end

        fb_bank_sdp #(
            .DATA_WIDTH(DATA_WIDTH),
            .DEPTH     (DEPTH),
            .ADDR_WIDTH(ADDR_WIDTH)
        ) u_ram (
            .clk  (clk),
            .we   (we),
            .waddr(waddr),
            .wdata(wdata),
            .raddr(bus.rd_addr),
            .rdata(bank_rdata[gi])
        );
    end

    assign rd_mux = rd_oor_reg ? CLEAR_VALUE : bank_rdata[rd_sel_reg];

`ifdef FB_READ_REG_EN
    logic [DATA_WIDTH-1:0] rd_data_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data_reg <= CLEAR_VALUE;
        end else begin
            rd_data_reg <= rd_mux;
        end
    end

    assign bus.rd_data = rd_data_reg;
`else
    assign bus.rd_data = rd_mux;
`endif

    assign bus.wr_ready    = (state_reg == DRAW);
    assign bus.swap_ack    = swap_ack;
    assign bus.display_sel = display_sel_reg;
    assign bus.clear_busy  = (state_reg != DRAW);
endmodule

// File: tb/tb_fb_pingpong_clear.sv
// Directed self-checking bench for fb_pingpong_clear (DEPTH=16, 4-bit words, clear value 0xA).
module tb_fb_pingpong_clear;
    localparam int DW = 4;
    localparam int AW = 5;
    localparam int DEPTH = 16;
    localparam logic [DW-1:0] CV = 4'hA;
`ifdef FB_READ_REG_EN
    localparam int RL = 2;
`else
    localparam int RL = 1;
`endif

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fb_pingpong_clear_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    fb_pingpong_clear #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW),
        .CLEAR_VALUE(CV)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_ready(input string tag);
        int n = 0;
        while (!bus.wr_ready && n < 40) begin
            step();
            n++;
        end
        chk(tag, n, DEPTH);
    endtask

    task automatic rd_chk(input string tag, input int a, input logic [DW-1:0] exp);
        bus.rd_addr = AW'(a);
        repeat (RL) step();
        chk(tag, bus.rd_data, exp);
    endtask

    task automatic write(input int a, input logic [DW-1:0] d);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(a);
        bus.wr_data  = d;
        step();
        bus.wr_valid = 1'b0;
    endtask

    task automatic swap(input string tag, input logic exp_sel);
        bus.swap_req = 1'b1;
        #1;
        chk({tag, "_ack"}, bus.swap_ack, 1'b1);
        step();
        bus.swap_req = 1'b0;
        chk({tag, "_sel"}, bus.display_sel, exp_sel);
        chk({tag, "_busy"}, bus.wr_ready, 1'b0);
        wait_ready({tag, "_clear_len"});
    endtask

    initial begin
        int acks;
        reset        = 1'b1;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;
        bus.swap_req = 1'b1;
        bus.rd_addr  = '0;
        repeat (2) step();

        chk("rst_wr_ready", bus.wr_ready, 1'b0);
        chk("rst_swap_ack", bus.swap_ack, 1'b0);
        chk("rst_clear_busy", bus.clear_busy, 1'b1);
        chk("rst_display_sel", bus.display_sel, 1'b0);
        chk("rst_rd_data", bus.rd_data, CV);

        bus.swap_req = 1'b0;
        reset = 1'b0;
        wait_ready("init_len");
        chk("init_done_busy", bus.clear_busy, 1'b0);
        for (int a = 0; a < DEPTH; a++) rd_chk("init_rd", a, CV);

        // Basic draw then swap.
        write(5, 4'h3);
        swap("swap1", 1'b1);
        rd_chk("swap1_rd5", 5, 4'h3);
        rd_chk("swap1_rd6", 6, CV);

        // Swap with nothing drawn, then swap again: the 0x3 bank comes back cleared.
        swap("swap2", 1'b0);
        rd_chk("swap2_rd5", 5, CV);
        swap("swap3", 1'b1);
        rd_chk("swap3_rd5", 5, CV);

        // Write and swap in the same cycle.
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(7);
        bus.wr_data  = 4'h6;
        bus.swap_req = 1'b1;
        #1;
        chk("ws_ack", bus.swap_ack, 1'b1);
        chk("ws_ready", bus.wr_ready, 1'b1);
        step();
        bus.wr_valid = 1'b0;
        bus.swap_req = 1'b0;
        chk("ws_sel", bus.display_sel, 1'b0);
        wait_ready("ws_clear_len");
        rd_chk("ws_rd7", 7, 4'h6);

        // swap_req held through CLEAR: exactly one more ack, only once DRAW resumes.
        bus.swap_req = 1'b1;
        #1;
        chk("held_ack0", bus.swap_ack, 1'b1);
        step();
        chk("held_sel1", bus.display_sel, 1'b1);
        acks = 0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            step();
            acks += int'(bus.swap_ack);
        end
        chk("held_acks_in_clear", acks, 0);
        step();
        chk("held_ack_draw", bus.swap_ack, 1'b1);
        chk("held_ready_draw", bus.wr_ready, 1'b1);
        step();
        bus.swap_req = 1'b0;
        chk("held_sel2", bus.display_sel, 1'b0);
        wait_ready("held_clear_len");

        // Reset in the middle of a CLEAR sweep discards all contents.
        write(9, 4'h2);
        bus.swap_req = 1'b1;
        step();
        bus.swap_req = 1'b0;
        rd_chk("mid_rd9", 9, 4'h2);
        step();
        reset = 1'b1;
        #1;
        chk("mid_rst_sel", bus.display_sel, 1'b0);
        chk("mid_rst_ready", bus.wr_ready, 1'b0);
        chk("mid_rst_busy", bus.clear_busy, 1'b1);
        chk("mid_rst_rd", bus.rd_data, CV);
        step();
        reset = 1'b0;
        wait_ready("reinit_len");
        rd_chk("reinit_rd9", 9, CV);

        // Out-of-range write is accepted but dropped; out-of-range read gives CV.
        write(4, 4'h9);
        bus.wr_valid = 1'b1;
        bus.wr_addr  = AW'(20);
        bus.wr_data  = 4'h5;
        #1;
        chk("oor_wr_ready", bus.wr_ready, 1'b1);
        step();
        bus.wr_valid = 1'b0;
        swap("swap_oor", 1'b1);
        rd_chk("oor_rd4", 4, 4'h9);
        bus.rd_addr = AW'(20);
        step();
`ifdef FB_READ_REG_EN
        chk("oor_rd20_lat1", bus.rd_data, 4'h9);
        step();
`endif
        chk("oor_rd20", bus.rd_data, CV);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
